// File: rtl/ffra_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : ffra_pipe_if
// Purpose  : Input/output handshake and data bundle for ffra_pipe.
// Revision : 1.0
// ============================================================================
interface ffra_pipe_if #(
    parameter int WIDTH = 32
) ();
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   ci;
    logic               in_acc;
    logic               in_clr;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH+1:0]   o;
    logic               ovf;

    modport master (
        output in_valid, a, b, ci, in_acc, in_clr, out_ready,
        input  in_ready, out_valid, o, ovf
    );

    modport slave (
        input  in_valid, a, b, ci, in_acc, in_clr, out_ready,
        output in_ready, out_valid, o, ovf
    );
endinterface
`default_nettype wire

// File: rtl/ffra_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ffra_pipe
// Purpose  : Pipelined exact a+b+ci adder with per-beat accumulate/clear,
//            wrap flag and valid/ready flow control with global stall.
// Revision : 1.0
// ============================================================================
module ffra_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  wire         clk,
    input  wire         rst,
    ffra_pipe_if.slave  bus
);
    localparam int c_OW  = WIDTH + 2;
    localparam int c_PRE = STAGES - 1;

    logic               w_stall;
    logic [c_OW-1:0]    w_csa_sum;
    logic [c_OW-1:0]    w_csa_car;

    logic               w_fin_valid;
    logic [c_OW-1:0]    w_fin_s;
    logic               w_fin_acc;
    logic               w_fin_clr;

    logic [c_OW-1:0]    w_base;
    logic [c_OW:0]      w_total;

    logic               r_out_valid;
    logic [c_OW-1:0]    r_o;
    logic               r_ovf;
    logic [c_OW-1:0]    r_accum;

    // Whole pipeline freezes while the output holds an unaccepted result.
    assign w_stall      = r_out_valid & ~bus.out_ready;
    assign bus.in_ready = ~w_stall;

    // Carry-save compression of the three operands.
    assign w_csa_sum = {2'b00, bus.a ^ bus.b ^ bus.ci};
    assign w_csa_car = {1'b0, (bus.a & bus.b) | (bus.a & bus.ci) | (bus.b & bus.ci), 1'b0};

    if (STAGES == 1) begin : g_direct
        assign w_fin_valid = bus.in_valid;
        assign w_fin_s     = w_csa_sum + w_csa_car;
        assign w_fin_acc   = bus.in_acc;
        assign w_fin_clr   = bus.in_clr;
    end else begin : g_piped
        logic               r_vld [c_PRE];
        logic [c_OW-1:0]    r_sum [c_PRE];
        logic [c_OW-1:0]    r_car [c_PRE];
        logic               r_acc [c_PRE];
        logic               r_clr [c_PRE];

        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int i = 0; i < c_PRE; i++) begin
                    r_vld[i] <= 1'b0;
                end
            end else if (!w_stall) begin
                r_vld[0] <= bus.in_valid;
                for (int i = 1; i < c_PRE; i++) begin
                    r_vld[i] <= r_vld[i-1];
                end
            end
        end

        // Payload moves only with a valid beat so idle-bus garbage never enters.
        always_ff @(posedge clk) begin
            if (!w_stall) begin
                if (bus.in_valid) begin
                    r_sum[0] <= w_csa_sum;
                    r_car[0] <= w_csa_car;
                    r_acc[0] <= bus.in_acc;
                    r_clr[0] <= bus.in_clr;
                end
                for (int i = 1; i < c_PRE; i++) begin
                    if (r_vld[i-1]) begin
                        r_sum[i] <= r_sum[i-1] + r_car[i-1];
                        r_car[i] <= '0;
                        r_acc[i] <= r_acc[i-1];
                        r_clr[i] <= r_clr[i-1];
                    end
                end
            end
        end

        assign w_fin_valid = r_vld[c_PRE-1];
        assign w_fin_s     = r_sum[c_PRE-1] + r_car[c_PRE-1];
        assign w_fin_acc   = r_acc[c_PRE-1];
        assign w_fin_clr   = r_clr[c_PRE-1];
    end

    assign w_base  = w_fin_clr ? '0 : r_accum;
    assign w_total = {1'b0, w_base} + {1'b0, w_fin_s};

    // Accumulator lives here so consecutive accumulate beats chain without a hazard.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_o         <= '0;
            r_ovf       <= 1'b0;
            r_accum     <= '0;
        end else if (!w_stall) begin
            r_out_valid <= w_fin_valid;
            if (w_fin_valid) begin
                if (w_fin_acc) begin
                    r_o     <= w_total[c_OW-1:0];
                    r_ovf   <= w_total[c_OW];
                    r_accum <= w_total[c_OW-1:0];
                end else begin
                    r_o     <= w_fin_s;
                    r_ovf   <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.o         = r_o;
    assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_ffra_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ffra_pipe
// Purpose  : Self-checking bench for ffra_pipe at STAGES=1..4, WIDTH=8.
// Revision : 1.0
// ============================================================================
module tb_ffra_pipe;
    localparam int c_W   = 8;
    localparam int c_OW  = c_W + 2;
    localparam int c_MOD = 1 << c_OW;
    localparam int c_NI  = 4;

    typedef struct packed {
        logic           v;
        logic [c_W-1:0] a;
        logic [c_W-1:0] b;
        logic [c_W-1:0] c;
        logic           acc;
        logic           clr;
    } beat_t;

    logic           clk     = 1'b0;
    logic           rst     = 1'b0;
    logic           d_valid = 1'b0;
    logic           d_acc   = 1'b0;
    logic           d_clr   = 1'b0;
    logic           d_ready = 1'b1;
    logic [c_W-1:0] d_a     = '0;
    logic [c_W-1:0] d_b     = '0;
    logic [c_W-1:0] d_ci    = '0;

    int n_err = 0;
    int n_chk = 0;
    int got_o[$];
    int got_ovf[$];

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < c_NI; gi++) begin : g_dut
        localparam int S = gi + 1;

        ffra_pipe_if #(.WIDTH(c_W)) bus ();

        assign bus.in_valid  = d_valid;
        assign bus.a         = d_a;
        assign bus.b         = d_b;
        assign bus.ci        = d_ci;
        assign bus.in_acc    = d_acc;
        assign bus.in_clr    = d_clr;
        assign bus.out_ready = d_ready;

        ffra_pipe #(.WIDTH(c_W), .STAGES(S)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );

        // Reference: a delay line of S-1 beat slots feeding one output slot.
        beat_t dl[$];
        beat_t nb;
        beat_t ob;
        int    m_o   = 0;
        int    m_acc = 0;
        int    s;
        int    t;
        bit    m_vld = 1'b0;
        bit    m_ovf = 1'b0;

        initial forever begin : p_model
            @(posedge clk);
            if (!rst) begin
                dl.delete();
                for (int i = 0; i < S - 1; i++) dl.push_back('0);
                m_vld = 1'b0;
                m_o   = 0;
                m_ovf = 1'b0;
                m_acc = 0;
            end else if (!(m_vld && !d_ready)) begin
                nb = {d_valid, d_a, d_b, d_ci, d_acc, d_clr};
                dl.push_back(nb);
                ob = dl.pop_front();
                m_vld = ob.v;
                if (ob.v) begin
                    s = int'(ob.a) + int'(ob.b) + int'(ob.c);
                    if (ob.acc) begin
                        t     = (ob.clr ? 0 : m_acc) + s;
                        m_o   = t % c_MOD;
                        m_ovf = (t >= c_MOD);
                        m_acc = m_o;
                    end else begin
                        m_o   = s;
                        m_ovf = 1'b0;
                    end
                end
            end
        end

        initial forever begin : p_cmp
            @(negedge clk);
            #3;
            if (rst) begin
                check($sformatf("s%0d_in_ready", S), longint'(bus.in_ready), longint'(!(m_vld && !d_ready)));
                check($sformatf("s%0d_out_valid", S), longint'(bus.out_valid), longint'(m_vld));
                if (m_vld) begin
                    check($sformatf("s%0d_o", S), longint'(bus.o), longint'(m_o));
                    check($sformatf("s%0d_ovf", S), longint'(bus.ovf), longint'(m_ovf));
                end
            end
        end

        if (S == 2) begin : g_log
            initial forever begin : p_log
                @(negedge clk);
                #3;
                if (rst && bus.out_valid && d_ready) begin
                    got_o.push_back(int'(bus.o));
                    got_ovf.push_back(int'(bus.ovf));
                end
            end
        end
    end

    task automatic drive(input bit v, input int a, input int b, input int c,
                         input bit acc, input bit clr, input bit rdy);
        @(negedge clk);
        d_valid = v;
        d_a     = v ? c_W'(a) : c_W'($urandom);
        d_b     = v ? c_W'(b) : c_W'($urandom);
        d_ci    = v ? c_W'(c) : c_W'($urandom);
        d_acc   = v ? acc : 1'($urandom);
        d_clr   = v ? clr : 1'($urandom);
        d_ready = rdy;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk_log(input string nm, input int idx, input int eo, input int eovf);
        if (idx >= got_o.size()) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: got no result expected 0x%0h", nm, eo);
        end else begin
            check({nm, "_o"}, longint'(got_o[idx]), longint'(eo));
            check({nm, "_ovf"}, longint'(got_ovf[idx]), longint'(eovf));
        end
    endtask

    initial begin
        int base;
        int idx;
        int rpat[6];
        rpat = '{1, 0, 0, 1, 0, 1};

        // Reset and single-beat latency at STAGES=2
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #3;
        check("rst_out_valid", longint'(g_dut[1].bus.out_valid), 0);
        check("rst_o", longint'(g_dut[1].bus.o), 0);
        check("rst_ovf", longint'(g_dut[1].bus.ovf), 0);
        check("rst_in_ready", longint'(g_dut[1].bus.in_ready), 1);

        drive(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
        idle(1);
        #3;
        check("lat_early_valid", longint'(g_dut[1].bus.out_valid), 0);
        check("lat_early_o", longint'(g_dut[1].bus.o), 0);
        idle(1);
        #3;
        check("lat_valid", longint'(g_dut[1].bus.out_valid), 1);
        check("lat_o", longint'(g_dut[1].bus.o), 10'h2FD);
        check("lat_ovf", longint'(g_dut[1].bus.ovf), 0);
        idle(4);

        // Accumulate chain
        base = got_o.size();
        drive(1'b1, 10, 0, 0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 20, 0, 0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 5,  0, 0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1,  0, 0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 0,  0, 0, 1'b1, 1'b0, 1'b1);
        idle(8);
        chk_log("acc0", base + 0, 10, 0);
        chk_log("acc1", base + 1, 30, 0);
        chk_log("acc2", base + 2, 5, 0);
        chk_log("acc3", base + 3, 31, 0);
        chk_log("acc_final", base + 4, 31, 0);

        // Wrap past 2^(WIDTH+2)
        base = got_o.size();
        drive(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 8'hF3, 0, 0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 8'h10, 0, 0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1, 0, 0, 1'b1, 1'b0, 1'b1);
        idle(8);
        chk_log("wrap_pre0", base + 0, 10'h2FD, 0);
        chk_log("wrap_pre1", base + 1, 10'h3F0, 0);
        chk_log("wrap", base + 2, 10'h000, 1);
        chk_log("wrap_next", base + 3, 10'h001, 0);

        // Backpressure with out_ready pattern 1,0,0,1,0,1
        base = got_o.size();
        idx  = 1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            d_ready = (cyc < 6) ? 1'(rpat[cyc]) : 1'b1;
            d_valid = (idx <= 4);
            d_a     = c_W'(idx);
            d_b     = '0;
            d_ci    = '0;
            d_acc   = 1'b0;
            d_clr   = 1'b0;
            #1;
            if (d_valid && g_dut[1].bus.in_ready) idx++;
        end
        check("bp_all_sent", idx, 5);
        for (int k = 0; k < 4; k++) chk_log($sformatf("bp%0d", k), base + k, k + 1, 0);
        check("bp_no_dup", got_o.size(), base + 4);

        // Random traffic with backpressure, then full-rate streaming
        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 9) < 7, int'($urandom), int'($urandom), int'($urandom),
                  1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, int'($urandom), int'($urandom), int'($urandom), 1'b0, 1'b0, 1'b1);
        end
        idle(8);

        // Reset with beats in flight under backpressure
        drive(1'b1, 7, 1, 1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8, 1, 1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 9, 1, 1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst     = 1'b0;
        d_valid = 1'b0;
        @(negedge clk);
        rst     = 1'b1;
        d_ready = 1'b1;
        #3;
        check("mrst_out_valid", longint'(g_dut[1].bus.out_valid), 0);
        base = got_o.size();
        idle(6);
        check("mrst_no_stale", got_o.size(), base);
        drive(1'b1, 3, 0, 0, 1'b1, 1'b0, 1'b1);
        idle(5);
        chk_log("mrst_acc_zero", base, 3, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ffra_pipe.md
Name: ffra_pipe

Overview:
- Parametrised successor to the registered three-operand adder in the user project.
- Computes a + b + ci at full precision over a configurable pipeline depth, with valid/ready flow control and backpressure.
- Adds a per-beat accumulate mode with clear and a wrap flag.
- Sits between the user_project_wrapper IO/LA pins and downstream logic.

Parameters:
- WIDTH, 32, operand width in bits (legal 4..64).
- STAGES, 2, pipeline registers from input acceptance to output (legal 1..4).

Ports:
- clk  input  1  system clock (wb_clk_i at wrapper).
- rst  input  1  reset. Synchronous, active-low: sampled on the clk rising edge, 0 = reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  WIDTH  operand C.
- in_acc  input  1  beat is accumulated (1) or plain sum (0).
- in_clr  input  1  zero the accumulator before this beat's accumulate.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- o  output  WIDTH+2  result.
- ovf  output  1  accumulate of this beat wrapped past 2^(WIDTH+2).

Behaviour:
- Reset, while rst=0 at a clk edge:
  - all stage valid bits cleared;
  - out_valid=0, o=0, ovf=0, accumulator=0;
  - in_ready=1 in the first cycle after release.
  - Reset mid-operation discards all in-flight beats; none are emitted.
- Transfers:
  - Input fire = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
  - a/b/ci/in_acc/in_clr are sampled only on input fire.
- Stall rule:
  - Global stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational from out_ready and out_valid only; no path from in_valid).
  - While stalled, no stage register changes; o, ovf and out_valid hold stable.
- Pipeline:
  - Each stage holds a valid bit plus payload.
  - Without stall, a beat accepted at edge k appears with out_valid=1 after edge k+STAGES-1, i.e. latency STAGES cycles, throughput 1 beat/cycle.
  - Bubbles (in_valid=0) propagate as invalid stages. Bubbles do not compact during a stall.
  - Internal split of carry-save compression and carry-propagate add across stages is free; only latency and results are observable.
- Arithmetic:
  - s = a + b + ci, zero-extended to WIDTH+2 bits. Exact: max 3*(2^WIDTH-1) fits.
- Final stage, evaluated when the beat loads into the output register:
  - in_acc=0: o = s; ovf = 0; accumulator unchanged.
  - in_acc=1: base = in_clr ? 0 : accumulator; {carry, r} = base + s; o = r; ovf = carry; accumulator <= r.
  - in_acc=0 with in_clr=1: in_clr ignored; accumulator unchanged.
  - Accumulator updates exactly once per accumulated beat, at output-register load, never during stall.
  - Back-to-back accumulate beats chain correctly with no hazard. Accumulator state lives only in the final stage.
- Boundaries:
  - Simultaneous output fire and new result: output register reloads same cycle (full throughput).
  - out_ready=1 with out_valid=0: no effect.
  - Accumulator wraps modulo 2^(WIDTH+2); ovf flags the beat that wrapped.
  - X on operands while in_valid=0 must not propagate to o or the accumulator.

Test Plan (WIDTH=8 unless noted):
- Reset/latency, STAGES=2: hold rst=0 for 3 cycles, then release; single beat a=0xFF, b=0xFF, ci=0xFF, in_acc=0 -> out_valid rises 2 cycles after acceptance, o=0x2FD, ovf=0; before that beat, out_valid=0 and o=0.
- Streaming, STAGES=1..4: 100 random beats with out_ready=1 -> every cycle accepted, outputs in order, each o = a+b+ci, latency = STAGES.
- Backpressure: stream 1,2,3,4 (a=n, b=0, ci=0) while out_ready toggles 1,0,0,1,0,1 -> in_ready=0 in exactly the stalled cycles, o holds during stall, sequence 1,2,3,4 delivered with no loss or duplication.
- Accumulate: beats (a=10, clr=1, acc=1), (a=20, acc=1), (a=5, acc=0), (a=1, acc=1) -> o = 10, 30, 5, 31; accumulator ends at 31.
- Wrap: preload accumulator 0x3F0 via clr beat, then accumulate a=0x10, b=0, ci=0 -> o=0x000, ovf=1; next accumulate a=1 -> o=0x001, ovf=0.
- Mid-flight reset: 3 beats in flight with out_ready=0, assert rst=0 for one cycle -> out_valid=0, accumulator=0, no stale beats emerge after release.
